// File: rtl/hough_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hough_pkg                                                     |
// | Purpose  : Shared types, requester indices and address-width helper for  |
// |            the hough subsystem's hysteresis BRAM read arbiter.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package hough_pkg;

  // Arbiter ownership state: nobody, the Hough voter, or the highlight feeder
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Requester indices into req/gnt/rvalid
  localparam int REQ_HOUGH     = 0;
  localparam int REQ_HIGHLIGHT = 1;

  // Bits needed to address every pixel of a w x h frame
  function automatic int addr_width(input int w, input int h);
    return $clog2(w * h);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rd_tag_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rd_tag_pipe                                                   |
// | Purpose  : Valid/tag delay line matching the BRAM read latency so read   |
// |            data can be steered back to the requester that issued it.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rd_tag_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  input  logic in_tag,
  output logic out_valid,
  output logic out_tag,
  output logic any_valid
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_tag;

  // Shift issued beats one stage per cycle; reset drops everything in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_tag   <= '0;
    end else begin
      r_valid[0] <= in_valid;
      r_tag[0]   <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_tag[i]   <= r_tag[i-1];
      end
    end
  end

  assign out_valid = r_valid[DEPTH-1];
  assign out_tag   = r_tag[DEPTH-1];
  assign any_valid = |r_valid;

endmodule
`default_nettype wire

// File: rtl/hyst_bram_rd_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hyst_bram_rd_arbiter                                          |
// | Purpose  : Shares the hysteresis bram_2d read port between the Hough     |
// |            voter (req 0) and the highlight readout (req 1) with burst    |
// |            hold, round-robin fairness and frame-ready gating; returns    |
// |            data through a latency-matched valid/tag pipe.                |
// | Options  : HYST_ARB_STATS_EN adds beats0/beats1/stall_cycles counters.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module hyst_bram_rd_arbiter
  import hough_pkg::*;
#(
  parameter int  REDUCED_WIDTH  = 512,
  parameter int  REDUCED_HEIGHT = 288,
  parameter int  MAX_BURST      = 16,
  parameter int  RD_LATENCY     = 1,
  localparam int ADDR_W         = addr_width(REDUCED_WIDTH, REDUCED_HEIGHT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bram_ready,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [7:0]        rdata,
  output logic [ADDR_W-1:0] hysteresis_bram_rd_addr,
  input  logic [7:0]        hysteresis_bram_rd_data,
  output logic              busy
`ifdef HYST_ARB_STATS_EN
  ,
  output logic [31:0]       beats0,
  output logic [31:0]       beats1,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_rr_ptr, w_rr_nxt;
  logic             w_win_vld;
  logic             w_win;
  logic             w_under;
  logic             w_grant;
  logic             w_pipe_vld;
  logic             w_pipe_tag;
  logic             w_pipe_any;

  // Pick this cycle's winner: the owner keeps the port until its burst is spent
  // and the other side is waiting, otherwise round-robin or the sole requester
  always_comb begin
    w_win_vld = 1'b0;
    w_win     = 1'b0;
    w_under   = (r_cnt < CNT_W'(MAX_BURST));
    if (r_state == OWN0 && req[REQ_HOUGH] && (w_under || !req[REQ_HIGHLIGHT])) begin
      w_win_vld = 1'b1;
      w_win     = 1'b0;
    end else if (r_state == OWN1 && req[REQ_HIGHLIGHT] && (w_under || !req[REQ_HOUGH])) begin
      w_win_vld = 1'b1;
      w_win     = 1'b1;
    end else if (&req) begin
      w_win_vld = 1'b1;
      w_win     = r_rr_ptr;
    end else if (req[REQ_HOUGH]) begin
      w_win_vld = 1'b1;
      w_win     = 1'b0;
    end else if (req[REQ_HIGHLIGHT]) begin
      w_win_vld = 1'b1;
      w_win     = 1'b1;
    end
  end

  // Nothing is granted before the frame is complete or while held in reset
  assign w_grant                 = w_win_vld & bram_ready & reset;
  assign gnt[REQ_HOUGH]          = w_grant & ~w_win;
  assign gnt[REQ_HIGHLIGHT]      = w_grant &  w_win;
  assign hysteresis_bram_rd_addr = w_grant ? (w_win ? addr1 : addr0) : '0;

  // Ownership/burst bookkeeping; a stalled frame (bram_ready=0) freezes it
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rr_nxt    = r_rr_ptr;
    if (w_grant) begin
      w_state_nxt = w_win ? OWN1 : OWN0;
      if (w_state_nxt == r_state) begin
        w_cnt_nxt = w_under ? (r_cnt + CNT_W'(1)) : r_cnt;
      end else begin
        w_cnt_nxt = CNT_W'(1);
      end
      w_rr_nxt = ~w_win;
    end else if (bram_ready) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end
  end

  // Arbiter state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rr_ptr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  rd_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rd_tag_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (w_grant),
    .in_tag    (w_win),
    .out_valid (w_pipe_vld),
    .out_tag   (w_pipe_tag),
    .any_valid (w_pipe_any)
  );

  assign rvalid[REQ_HOUGH]     = w_pipe_vld & ~w_pipe_tag;
  assign rvalid[REQ_HIGHLIGHT] = w_pipe_vld &  w_pipe_tag;
  assign rdata                 = hysteresis_bram_rd_data;
  assign busy                  = (r_state != IDLE) | w_pipe_any;

`ifdef HYST_ARB_STATS_EN
  logic        r_ready_q;
  logic [31:0] r_beats0;
  logic [31:0] r_beats1;
  logic [31:0] r_stall;

  // Saturating activity counters, restarted at the start of every new frame
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ready_q <= 1'b0;
      r_beats0  <= '0;
      r_beats1  <= '0;
      r_stall   <= '0;
    end else begin
      r_ready_q <= bram_ready;
      if (bram_ready && !r_ready_q) begin
        r_beats0 <= '0;
        r_beats1 <= '0;
        r_stall  <= '0;
      end else begin
        if (gnt[REQ_HOUGH] && (r_beats0 != '1)) begin
          r_beats0 <= r_beats0 + 32'd1;
        end
        if (gnt[REQ_HIGHLIGHT] && (r_beats1 != '1)) begin
          r_beats1 <= r_beats1 + 32'd1;
        end
        if ((|(req & ~gnt)) && (r_stall != '1)) begin
          r_stall <= r_stall + 32'd1;
        end
      end
    end
  end

  assign beats0       = r_beats0;
  assign beats1       = r_beats1;
  assign stall_cycles = r_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hyst_bram_rd_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_hyst_bram_rd_arbiter                                       |
// | Purpose  : Self-checking bench: directed scenarios plus random traffic   |
// |            compared against a behavioural arbitration/return model.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_hyst_bram_rd_arbiter;
  import hough_pkg::*;

  localparam int RW  = 512;
  localparam int RH  = 288;
  localparam int MB  = 4;
  localparam int LAT = 2;
  localparam int AW  = addr_width(RW, RH);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          bram_ready = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [AW-1:0] addr0 = '0;
  logic [AW-1:0] addr1 = '0;
  logic [1:0]    gnt;
  logic [1:0]    rvalid;
  logic [7:0]    rdata;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy;
`ifdef HYST_ARB_STATS_EN
  logic [31:0]   beats0;
  logic [31:0]   beats1;
  logic [31:0]   stall_cycles;
`endif

  hyst_bram_rd_arbiter #(
    .REDUCED_WIDTH  (RW),
    .REDUCED_HEIGHT (RH),
    .MAX_BURST      (MB),
    .RD_LATENCY     (LAT)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .bram_ready              (bram_ready),
    .req                     (req),
    .addr0                   (addr0),
    .addr1                   (addr1),
    .gnt                     (gnt),
    .rvalid                  (rvalid),
    .rdata                   (rdata),
    .hysteresis_bram_rd_addr (rd_addr),
    .hysteresis_bram_rd_data (rd_data),
    .busy                    (busy)
`ifdef HYST_ARB_STATS_EN
    ,
    .beats0                  (beats0),
    .beats1                  (beats1),
    .stall_cycles            (stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  // BRAM stand-in: contents are a fixed function of the address, LAT-cycle read
  function automatic logic [7:0] mem_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {6'h16, a[17:16]};
  endfunction

  logic [AW-1:0] bram_pipe [LAT];
  always @(posedge clock) begin
    bram_pipe[0] <= rd_addr;
    for (int i = 1; i < LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
  end
  assign rd_data = mem_val(bram_pipe[LAT-1]);

  // Reference model: who owns the port, how long its run is, whose turn a tie is,
  // and the list of beats still owed back to requesters
  typedef struct {
    int            due;
    int            tag;
    logic [AW-1:0] a;
  } beat_t;

  int    m_owner = -1;
  int    m_run   = 0;
  int    m_turn  = 0;
  int    cyc     = 0;
  beat_t owed[$];

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endfunction

  task automatic step(input logic rst, input logic rdy, input logic [1:0] rq,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    int            w;
    logic          granted;
    logic [1:0]    exp_gnt;
    logic [AW-1:0] exp_addr;
    logic [1:0]    exp_rv;
    logic [7:0]    exp_rd;
    logic          exp_busy;
    reset      = rst;
    bram_ready = rdy;
    req        = rq;
    addr0      = a0;
    addr1      = a1;
    if (!rst) begin
      m_owner = -1;
      m_run   = 0;
      m_turn  = 0;
      owed.delete();
    end
    #3;
    w = -1;
    if (rst) begin
      if (m_owner >= 0 && rq[m_owner] && (m_run < MB || !rq[1-m_owner])) w = m_owner;
      else if (rq == 2'b11) w = m_turn;
      else if (rq[0])       w = 0;
      else if (rq[1])       w = 1;
    end
    granted  = (w >= 0) && rdy;
    exp_gnt  = granted ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
    exp_addr = granted ? ((w == 1) ? a1 : a0) : '0;
    exp_rv   = 2'b00;
    exp_rd   = 8'h00;
    if (owed.size() > 0 && owed[0].due == cyc) begin
      exp_rv = (owed[0].tag == 1) ? 2'b10 : 2'b01;
      exp_rd = mem_val(owed[0].a);
    end
    exp_busy = (m_owner >= 0) || (owed.size() > 0);
    chk("gnt",     32'(gnt),     32'(exp_gnt));
    chk("rd_addr", 32'(rd_addr), 32'(exp_addr));
    chk("rvalid",  32'(rvalid),  32'(exp_rv));
    if (exp_rv != 2'b00) chk("rdata", 32'(rdata), 32'(exp_rd));
    chk("busy",    32'(busy),    32'(exp_busy));
    @(posedge clock);
    if (owed.size() > 0 && owed[0].due == cyc) void'(owed.pop_front());
    if (rst && rdy) begin
      if (granted) begin
        m_run   = (w == m_owner) ? ((m_run < MB) ? m_run + 1 : MB) : 1;
        m_owner = w;
        m_turn  = 1 - w;
        owed.push_back('{due: cyc + LAT, tag: w, a: exp_addr});
      end else begin
        m_owner = -1;
        m_run   = 0;
      end
    end
    cyc++;
    #1;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return AW'($urandom());
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 2'b00, rnd_addr(), rnd_addr());
  endtask

  initial begin
    // establish a clean asynchronous reset before any checking
    #2 reset = 1'b0;
    @(posedge clock);
    #1;

    // held in reset with both requesting: everything quiet
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b11, rnd_addr(), rnd_addr());

    // single requester 0 streaming addresses 0..9
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 2'b01, AW'(i), rnd_addr());
    idle(3);

    // both request continuously: bursts of MB, no bubbles at switches
    for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 2'b11, rnd_addr(), rnd_addr());
    idle(3);

    // req1 alone, then req0 joins on the third cycle
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 2'b10, rnd_addr(), rnd_addr());
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 2'b11, rnd_addr(), rnd_addr());
    idle(4);

    // frame not ready: no grants, then ready
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2'b11, rnd_addr(), rnd_addr());
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'b11, rnd_addr(), rnd_addr());

    // ready drops mid-burst: in-flight beats still return
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'b11, rnd_addr(), rnd_addr());
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 2'b11, rnd_addr(), rnd_addr());
    idle(3);

    // alternating single requesters
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, rnd_addr(), rnd_addr());
    idle(3);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'b1, ($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), rnd_addr(), rnd_addr());
    idle(3);

    // reset one cycle after a grant: that beat never returns
    step(1'b1, 1'b1, 2'b01, rnd_addr(), rnd_addr());
    step(1'b0, 1'b1, 2'b01, rnd_addr(), rnd_addr());
    step(1'b0, 1'b1, 2'b00, rnd_addr(), rnd_addr());
    idle(3);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 2'b11, rnd_addr(), rnd_addr());
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
